alu_cmd_sequencer: RTL

Command queue and issue controller sitting directly upstream of the 16-bit registered ALU. It accepts operand/function commands over a valid/ready handshake and buffers them in a small FIFO. It drives the ALU's `A`, `B` and `ALU_FUN` inputs one command at a time, waits out the ALU latency, then captures `ALU_OUT` and the four flags into a result register. That register is returned over a second valid/ready handshake, in command order.

---
 rtl/alu_cmd_sequencer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/alu_cmd_sequencer.sv
// Command FIFO and issue controller for a registered 16-bit ALU.
// Issues one command at a time, captures the result, returns it in order.
module alu_cmd_sequencer #(
    parameter int DATA_WIDTH  = 16,
    parameter int FUN_WIDTH   = 4,
    parameter int DEPTH       = 4,
    parameter int ALU_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [DATA_WIDTH-1:0]   cmd_a,
    input  logic [DATA_WIDTH-1:0]   cmd_b,
    input  logic [FUN_WIDTH-1:0]    cmd_fun,
    output logic [DATA_WIDTH-1:0]   A,
    output logic [DATA_WIDTH-1:0]   B,
    output logic [FUN_WIDTH-1:0]    ALU_FUN,
    input  logic [DATA_WIDTH-1:0]   ALU_OUT,
    input  logic                    Arith_Flag,
    input  logic                    Logic_Flag,
    input  logic                    CMP_Flag,
    input  logic                    Shift_Flag,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [DATA_WIDTH-1:0]   res_data,
    output logic [3:0]              res_flags,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 2 * DATA_WIDTH + FUN_WIDTH;
    localparam int CW = (ALU_LATENCY < 1) ? 1 : $clog2(ALU_LATENCY + 1);
    localparam logic [AW:0] PONE = (AW + 1)'(1);
    localparam logic [CW-1:0] CLAT = CW'(ALU_LATENCY);
    localparam logic [CW-1:0] CONE = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_HOLD
    } state_t;

    logic [EW-1:0]         mem_q [DEPTH];
    logic [EW-1:0]         mem_d [DEPTH];
    logic [AW:0]           wptr_q, wptr_d;
    logic [AW:0]           rptr_q, rptr_d;
    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [FUN_WIDTH-1:0]  fun_q, fun_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [3:0]            rflags_q, rflags_d;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [EW-1:0] head;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign cmd_ready = !full && !rst;
    assign push      = cmd_valid && cmd_ready;
    assign head      = mem_q[rptr_q[AW-1:0]];
    assign level     = wptr_q - rptr_q;
    assign busy      = !empty || (state_q != ST_IDLE);

    assign A         = a_q;
    assign B         = b_q;
    assign ALU_FUN   = fun_q;
    assign res_valid = rvalid_q;
    assign res_data  = rdata_q;
    assign res_flags = rflags_q;

    // FIFO write and pointer update; a pop only ever sees older entries
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        mem_d  = mem_q;
        if (push) begin
            mem_d[wptr_q[AW-1:0]] = {cmd_a, cmd_b, cmd_fun};
            wptr_d = wptr_q + PONE;
        end
        if (pop) begin
            rptr_d = rptr_q + PONE;
        end
    end

    // Issue FSM: pop and drive ALU, count latency, hold result for consumer
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        fun_d    = fun_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rflags_d = rflags_q;
        pop      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    rvalid_d = 1'b1;
                    rdata_d  = ALU_OUT;
                    rflags_d = {Arith_Flag, Logic_Flag,
                                CMP_Flag, Shift_Flag};
                    state_d  = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - CONE;
                end
            end
            ST_HOLD: begin
                if (res_ready) begin
                    rvalid_d = 1'b0;
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (pop) begin
            a_d   = head[EW-1 -: DATA_WIDTH];
            b_d   = head[FUN_WIDTH +: DATA_WIDTH];
            fun_d = head[FUN_WIDTH-1:0];
            cnt_d = CLAT;
        end
    end

    // State and datapath registers; reset drops queue, command and result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wptr_q   <= '0;
            rptr_q   <= '0;
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            fun_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rflags_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            fun_q    <= fun_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rflags_q <= rflags_d;
        end
    end

endmodule
